// File: rtl/sbox_layer_ctrl.sv
// Applies the 5-bit sbox to every word of the cipher state.
// LANES sbox instances are time-shared across NWORDS words, with valid/ready on both sides.

module sbox (
    input  logic [4:0] i_x,
    output logic [4:0] o_y
);
    always_comb begin
        o_y = 5'd0;
        case (i_x)
            5'd0:  o_y = 5'd0;
            5'd1:  o_y = 5'd4;
            5'd2:  o_y = 5'd14;
            5'd3:  o_y = 5'd9;
            5'd4:  o_y = 5'd13;
            5'd5:  o_y = 5'd11;
            5'd6:  o_y = 5'd30;
            5'd7:  o_y = 5'd27;
            5'd8:  o_y = 5'd28;
            5'd9:  o_y = 5'd20;
            5'd10: o_y = 5'd19;
            5'd11: o_y = 5'd24;
            5'd12: o_y = 5'd23;
            5'd13: o_y = 5'd29;
            5'd14: o_y = 5'd5;
            5'd15: o_y = 5'd12;
            5'd16: o_y = 5'd15;
            5'd17: o_y = 5'd17;
            5'd18: o_y = 5'd8;
            5'd19: o_y = 5'd21;
            5'd20: o_y = 5'd3;
            5'd21: o_y = 5'd31;
            5'd22: o_y = 5'd25;
            5'd23: o_y = 5'd6;
            5'd24: o_y = 5'd16;
            5'd25: o_y = 5'd2;
            5'd26: o_y = 5'd1;
            5'd27: o_y = 5'd7;
            5'd28: o_y = 5'd10;
            5'd29: o_y = 5'd22;
            5'd30: o_y = 5'd26;
            5'd31: o_y = 5'd18;
            default: o_y = 5'd0;
        endcase
    end
endmodule

module sbox_layer_ctrl #(
    parameter int NWORDS = 26,
    parameter int LANES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5*NWORDS-1:0] in_state,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [5*NWORDS-1:0] out_state,
    output logic                busy
);
    localparam int NSTEP = (NWORDS + LANES - 1) / LANES;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    // Word index must reach NSTEP*LANES-1 so the padding lanes of the last step never alias a real word.
    localparam int IW    = $clog2(NSTEP * LANES + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_step;
    logic [CW-1:0]        w_step_nxt;
    logic [5*NWORDS-1:0]  r_work;
    logic [5*NWORDS-1:0]  w_work_nxt;

    logic [IW-1:0]        w_idx     [LANES];
    logic [4:0]           w_lane_res[LANES];

    genvar j;
    generate
        for (j = 0; j < LANES; j++) begin : g_lane
            logic [4:0] w_lane_in;
            logic [4:0] w_lane_out;

            assign w_idx[j] = IW'(r_step) * IW'(LANES) + IW'(j);

            always_comb begin
                w_lane_in = 5'd0;
                for (int w = 0; w < NWORDS; w++) begin
                    if (w_idx[j] == IW'(w)) begin
                        w_lane_in = r_work[5*w +: 5];
                    end
                end
            end

            sbox u_sbox (
                .i_x(w_lane_in),
                .o_y(w_lane_out)
            );

            assign w_lane_res[j] = w_lane_out;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_work  <= w_work_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_work_nxt  = r_work;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_work_nxt  = in_state;
                    w_step_nxt  = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    for (int w = 0; w < NWORDS; w++) begin
                        if (w_idx[l] == IW'(w)) begin
                            w_work_nxt[5*w +: 5] = w_lane_res[l];
                        end
                    end
                end
                if (r_step == LAST_STEP) begin
                    w_state_nxt = ST_DONE;
                    w_step_nxt  = '0;
                end else begin
                    w_step_nxt  = r_step + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_state = r_work;

endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// Bench for sbox_layer_ctrl: four instances (LANES = 4, 1, 5, 26) share one stimulus stream
// and are checked every cycle against a word-level model, plus hand-computed literal expectations.

module tb_sbox_layer_ctrl;
    localparam int NW   = 26;
    localparam int SW   = 5 * NW;
    localparam int NI   = 4;
    localparam int CWID = SW + 3;

    localparam logic [4:0] SBOX_T [32] = '{
        5'd0,  5'd4,  5'd14, 5'd9,  5'd13, 5'd11, 5'd30, 5'd27,
        5'd28, 5'd20, 5'd19, 5'd24, 5'd23, 5'd29, 5'd5,  5'd12,
        5'd15, 5'd17, 5'd8,  5'd21, 5'd3,  5'd31, 5'd25, 5'd6,
        5'd16, 5'd2,  5'd1,  5'd7,  5'd10, 5'd22, 5'd26, 5'd18
    };

    localparam logic [4:0] EXP3 [NW] = '{
        5'd0,  5'd4,  5'd14, 5'd9,  5'd13, 5'd11, 5'd30, 5'd27,
        5'd28, 5'd20, 5'd19, 5'd24, 5'd23, 5'd29, 5'd5,  5'd12,
        5'd15, 5'd17, 5'd8,  5'd21, 5'd3,  5'd31, 5'd25, 5'd6,
        5'd16, 5'd2
    };

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inValid = 1'b0;
    logic          outReady = 1'b1;
    logic [SW-1:0] inState = '0;

    logic          inReadyV  [NI];
    logic          outValidV [NI];
    logic          busyV     [NI];
    logic [SW-1:0] outStateV [NI];

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : gDut
            localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 5 : 26;
            logic          ir;
            logic          ov;
            logic          bz;
            logic [SW-1:0] os;

            sbox_layer_ctrl #(.NWORDS(NW), .LANES(L)) dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (inValid),
                .in_ready (ir),
                .in_state (inState),
                .out_valid(ov),
                .out_ready(outReady),
                .out_state(os),
                .busy     (bz)
            );

            assign inReadyV[g]  = ir;
            assign outValidV[g] = ov;
            assign busyV[g]     = bz;
            assign outStateV[g] = os;
        end
    endgenerate

    function automatic int laneOf(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 5;
            default: return 26;
        endcase
    endfunction

    function automatic int nstepOf(input int g);
        return (NW + laneOf(g) - 1) / laneOf(g);
    endfunction

    // Words below 'limit' have been substituted, the rest still hold their input value.
    function automatic logic [SW-1:0] partialSub(input logic [SW-1:0] src, input int limit);
        logic [SW-1:0] res;
        res = src;
        for (int w = 0; w < NW; w++) begin
            if (w < limit) res[5*w +: 5] = SBOX_T[src[5*w +: 5]];
        end
        return res;
    endfunction

    function automatic logic [SW-1:0] fillWords(input logic [4:0] v);
        logic [SW-1:0] res;
        for (int w = 0; w < NW; w++) res[5*w +: 5] = v;
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [CWID-1:0] act, input logic [CWID-1:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectorCount++;
        missCount++;
        $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Model: per instance, whether a state is in flight, how many steps have elapsed, and the result left behind.
    logic          mBusy  [NI] = '{default: 1'b0};
    int            mEdges [NI] = '{default: 0};
    logic [SW-1:0] mSrc   [NI] = '{default: '0};
    logic [SW-1:0] mLast  [NI] = '{default: '0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NI; g++) begin
                mBusy[g]  <= 1'b0;
                mEdges[g] <= 0;
                mSrc[g]   <= '0;
                mLast[g]  <= '0;
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                if (!mBusy[g]) begin
                    if (inValid) begin
                        mBusy[g]  <= 1'b1;
                        mEdges[g] <= 0;
                        mSrc[g]   <= inState;
                    end
                end else if (mEdges[g] < nstepOf(g)) begin
                    mEdges[g] <= mEdges[g] + 1;
                end else if (outReady) begin
                    mBusy[g] <= 1'b0;
                    mLast[g] <= partialSub(mSrc[g], NW);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < NI; g++) begin
                logic [SW-1:0] expState;
                logic          expValid;
                expState = mBusy[g] ? partialSub(mSrc[g], mEdges[g] * laneOf(g)) : mLast[g];
                expValid = mBusy[g] && (mEdges[g] == nstepOf(g));
                checkOutput($sformatf("model_inst%0d", g),
                            {inReadyV[g], outValidV[g], busyV[g], outStateV[g]},
                            {!mBusy[g], expValid, mBusy[g], expState});
            end
        end
    end

    task automatic waitAllIdle(input string name);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (inReadyV[0] && inReadyV[1] && inReadyV[2] && inReadyV[3]) return;
        end
        reportTimeout(name);
    endtask

    task automatic waitAllDone(input string name);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (outValidV[0] && outValidV[1] && outValidV[2] && outValidV[3]) return;
        end
        reportTimeout(name);
    endtask

    // Offers one state for a single cycle once every instance is idle; returns just after the accept edge.
    task automatic applyStimulus(input logic [SW-1:0] v);
        waitAllIdle("idle_before_accept");
        @(posedge clk);
        #2;
        inValid = 1'b1;
        inState = v;
        @(posedge clk);
        #2;
        inValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [SW-1:0] seq;
        logic [SW-1:0] exp3;
        logic [SW-1:0] mid4;

        for (int w = 0; w < NW; w++) begin
            seq[5*w +: 5]  = 5'(w);
            exp3[5*w +: 5] = EXP3[w];
            mid4[5*w +: 5] = (w < 4) ? 5'd18 : 5'd31;
        end

        #1 rst = 1'b1;
        #2;
        for (int g = 0; g < NI; g++)
            checkOutput($sformatf("reset_inst%0d", g),
                        {inReadyV[g], outValidV[g], busyV[g], outStateV[g]},
                        {1'b1, 1'b0, 1'b0, {SW{1'b0}}});
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] all-zero state, latency check");
        applyStimulus('0);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("latency_edge%0d", i), CWID'(outValidV[0]), CWID'(i == 7));
        end
        checkOutput("zero_result", CWID'(outStateV[0]), CWID'(0));
        @(posedge clk);
        @(negedge clk);
        checkOutput("ready_after_handshake", CWID'(inReadyV[0]), CWID'(1'b1));

        $display("[TB] reset asserted mid-run");
        applyStimulus(seq);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < NI; g++)
            checkOutput($sformatf("midrun_reset_inst%0d", g),
                        {inReadyV[g], outValidV[g], busyV[g], outStateV[g]},
                        {1'b1, 1'b0, 1'b0, {SW{1'b0}}});
        @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] word i = i");
        applyStimulus(seq);
        waitAllIdle("seq_complete");
        for (int g = 0; g < NI; g++)
            checkOutput($sformatf("seq_result_inst%0d", g), CWID'(outStateV[g]), CWID'(exp3));

        $display("[TB] all words 31");
        applyStimulus(fillWords(5'd31));
        @(posedge clk);
        @(negedge clk);
        checkOutput("ones_after_one_step", CWID'(outStateV[0]), CWID'(mid4));
        waitAllIdle("ones_complete");
        for (int g = 0; g < NI; g++)
            checkOutput($sformatf("ones_result_inst%0d", g), CWID'(outStateV[g]), CWID'(fillWords(5'd18)));

        $display("[TB] backpressure");
        outReady = 1'b0;
        applyStimulus(fillWords(5'd9));
        waitAllDone("bp_done");
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            inValid = c[0];
            for (int w = 0; w < NW; w++) inState[5*w +: 5] = 5'($urandom);
        end
        @(negedge clk);
        checkOutput("bp_state_stable", CWID'(outStateV[0]), CWID'(fillWords(5'd20)));
        checkOutput("bp_no_ready", CWID'({inReadyV[0], outValidV[0]}), CWID'(2'b01));
        @(posedge clk);
        #2;
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++)
            checkOutput($sformatf("bp_release_inst%0d", g),
                        CWID'({inReadyV[g], outValidV[g], busyV[g]}), CWID'(3'b100));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/sbox_layer_ctrl.md
Name: sbox_layer_ctrl

Overview:
Sequences the 5-bit `sbox` primitive across the full cipher state. LANES `sbox` instances are time-multiplexed over NWORDS 5-bit words, so one complete substitution layer takes several cycles. Handshakes are valid/ready on both sides. It sits between the round-function datapath and the round controller.

Parameters:
NWORDS, 26, number of 5-bit words in the state; the state width is 5*NWORDS.
LANES, 4, number of `sbox` instances, i.e. words substituted per cycle; legal range 1..NWORDS.
(Derived, not overridable) NSTEP = ceil(NWORDS/LANES) = 7 at defaults; CW = clog2(NSTEP), minimum 1.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  in_state is valid.
in_ready  out  1  block can accept a state.
in_state  in  5*NWORDS  input state; word i = bits [5i+4:5i].
out_valid  out  1  out_state holds a completed substituted state.
out_ready  in  1  consumer accepts out_state.
out_state  out  5*NWORDS  substituted state; word i = S(in word i).
busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE; step counter `step` of CW bits; working register `work` of 5*NWORDS bits.
- Reset (async, rst=1): state=IDLE, step=0, work=0. Outputs during and after reset: in_ready=1, out_valid=0, busy=0, out_state=0.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state!=IDLE). out_state = work at all times.
- IDLE:
  - On in_valid&&in_ready: work <= in_state, step <= 0, state <= RUN.
  - Otherwise hold.
- RUN, each cycle:
  - Lane j (0..LANES-1) addresses word w = step*LANES + j.
  - If w < NWORDS: work word w <= S(work word w). Lanes with w >= NWORDS (partial last step) write nothing.
  - Words not addressed this cycle are unchanged.
  - step == NSTEP-1 -> state <= DONE, step <= 0; else step <= step+1.
- DONE:
  - Hold work.
  - On out_ready: state <= IDLE.
  - No new input is accepted in the same cycle as the output handshake; in_ready rises the cycle after.
- Latency: if accept occurs at edge k, out_valid is high after edge k+NSTEP. Minimum spacing between accepts is NSTEP+2 cycles.
- Inputs are ignored outside their states:
  - in_valid is ignored in RUN/DONE.
  - out_ready is ignored in IDLE/RUN.
  - Changes on in_state after acceptance have no effect.
- Backpressure: out_ready low holds DONE indefinitely; out_state stays stable.
- Reset mid-operation: rst asserted in RUN or DONE immediately aborts, clears work and returns to IDLE. No partial result is ever flagged valid.
- S is exactly the existing `sbox` mapping, one `sbox` instance per lane, with a combinational lane mux. Index arithmetic is done in widths sufficient for NSTEP*LANES, with no wrap.

Test Plan:
1. Reset: assert rst mid-RUN at defaults -> in_ready=1, out_valid=0, busy=0, out_state=0 with no clock edge needed; next accept completes normally.
2. All-zero in_state, out_ready=1 -> out_valid exactly 7 cycles after the accept edge, out_state=0; in_ready=1 one cycle after the output handshake.
3. Word i = i (i=0..25) -> out words = 0,4,14,9,13,11,30,27,28,20,19,24,23,29,5,12,15,17,8,21,3,31,25,6,16,2.
4. All words 31 -> all words 18. Also mid-RUN after 1 step (LANES=4): words 0..3 = 18, words 4..25 still 31.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid/in_state -> out_state stable, in_ready=0, no second accept; release -> IDLE.
6. Parameter sweep: NWORDS=26 with LANES=1, 5, 26 (NSTEP=26, 6, 1) -> latency equals NSTEP, results identical to scenario 3, and partial last step (LANES=5) corrupts no word.
